// File: rtl/ofifo_flex_pkg.sv
// Shared sizing helpers for the output FIFO bank.
// Also consumed by the psum controller for row counts.
package ofifo_flex_pkg;

  localparam int COL_D      = 8;
  localparam int BW_D       = 16;
  localparam int DEPTH_D    = 64;
  localparam int AFULL_TH_D = 60;

  function automatic int ptr_w(input int d);
    return (d > 1) ? $clog2(d) : 1;
  endfunction

  function automatic int cnt_w(input int d);
    return $clog2(d) + 1;
  endfunction

endpackage

// File: rtl/ofifo_flex_if.sv
// Column write / row read bundle of the output FIFO bank.
// Carries the status flags seen by the drain side.
interface ofifo_flex_if
  import ofifo_flex_pkg::*;
#(
  parameter int col   = COL_D,
  parameter int bw    = BW_D,
  parameter int depth = DEPTH_D
);

  localparam int CW = cnt_w(depth);

  logic [col*bw-1:0] in;
  logic [col-1:0]    wr;
  logic              rd;
  logic              flush;
  logic              clr_err;
  logic [col*bw-1:0] out;
  logic              o_valid;
  logic              o_ready;
  logic              o_full;
  logic              o_afull;
  logic [CW-1:0]     o_rows;
  logic              o_ovf;
  logic              o_unf;

  modport master (
    output in, wr, rd, flush, clr_err,
    input  out, o_valid, o_ready, o_full,
    input  o_afull, o_rows, o_ovf, o_unf
  );

  modport slave (
    input  in, wr, rd, flush, clr_err,
    output out, o_valid, o_ready, o_full,
    output o_afull, o_rows, o_ovf, o_unf
  );

endinterface

// File: rtl/ofifo_flex_col.sv
// One column FIFO: RAM array with wrapping pointers.
// Head word is presented combinationally; caller must not pop empty.
module ofifo_flex_col
  import ofifo_flex_pkg::*;
#(
  parameter int depth = DEPTH_D,
  parameter int bw    = BW_D
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  logic                      pop,
  input  logic                      flush,
  input  logic [bw-1:0]             din,
  output logic [cnt_w(depth)-1:0]   count,
  output logic [bw-1:0]             dout,
  output logic                      empty,
  output logic                      full
);

  localparam int CW = cnt_w(depth);
  localparam int PW = ptr_w(depth);

  logic [bw-1:0] mem [depth];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wp    <= '0;
      rp    <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wp <= wp + PW'(1);
      if (pop)  rp <= rp + PW'(1);
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end

  assign count = cnt_q;
  assign dout  = mem[rp];
  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(depth));

endmodule

// File: rtl/ofifo_flex.sv
// Output FIFO bank: per-column writes, row-aligned registered pop,
// status flags from registered counts, sticky error flags.
module ofifo_flex
  import ofifo_flex_pkg::*;
#(
  parameter int col      = COL_D,
  parameter int bw       = BW_D,
  parameter int depth    = DEPTH_D,
  parameter int afull_th = AFULL_TH_D
) (
  input  logic         clk,
  input  logic         reset,
  ofifo_flex_if.slave  bus
);

  localparam int CW = cnt_w(depth);

  logic [CW-1:0]     cnt [col];
  logic [bw-1:0]     dout [col];
  logic [col-1:0]    empty;
  logic [col-1:0]    full;
  logic [col-1:0]    push;
  logic [col*bw-1:0] head;
  logic [col*bw-1:0] out_q;
  logic [CW-1:0]     rows;
  logic              afull;
  logic              valid;
  logic              pop_acc;
  logic              ovf_set;
  logic              unf_set;
  logic              ovf_q;
  logic              unf_q;

  assign valid   = ~|empty;
  assign pop_acc = bus.rd && valid && !bus.flush;
  assign ovf_set = |(bus.wr & full) && !pop_acc && !bus.flush;
  assign unf_set = bus.rd && !valid && !bus.flush;

  for (genvar i = 0; i < col; i++) begin : g_col
    assign push[i] = bus.wr[i] && !bus.flush && (!full[i] || pop_acc);
    assign head[i*bw +: bw] = dout[i];

    ofifo_flex_col #(
      .depth (depth),
      .bw    (bw)
    ) u_col (
      .clk   (clk),
      .reset (reset),
      .push  (push[i]),
      .pop   (pop_acc),
      .flush (bus.flush),
      .din   (bus.in[i*bw +: bw]),
      .count (cnt[i]),
      .dout  (dout[i]),
      .empty (empty[i]),
      .full  (full[i])
    );
  end

  always_comb begin
    rows  = cnt[0];
    afull = 1'b0;
    for (int i = 0; i < col; i++) begin
      if (cnt[i] < rows) rows = cnt[i];
      if (cnt[i] >= CW'(afull_th)) afull = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q <= '0;
    end else if (pop_acc) begin
      out_q <= head;
    end
  end

  // a fresh error beats a same-cycle clear; flush leaves flags alone
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (!bus.flush) begin
      ovf_q <= ovf_set || (ovf_q && !bus.clr_err);
      unf_q <= unf_set || (unf_q && !bus.clr_err);
    end
  end

  assign bus.out     = out_q;
  assign bus.o_valid = valid;
  assign bus.o_ready = ~|full;
  assign bus.o_full  = &full;
  assign bus.o_afull = afull;
  assign bus.o_rows  = rows;
  assign bus.o_ovf   = ovf_q;
  assign bus.o_unf   = unf_q;

endmodule

// File: tb/tb_ofifo_flex.sv
// Bench for ofifo_flex: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then random traffic.
module tb_ofifo_flex;

  localparam int COL   = 8;
  localparam int BW    = 16;
  localparam int DEPTH = 64;
  localparam int TH    = 60;
  localparam int DW    = COL * BW;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ofifo_flex_if #(.col(COL), .bw(BW), .depth(DEPTH)) bus ();

  ofifo_flex #(
    .col(COL), .bw(BW), .depth(DEPTH), .afull_th(TH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  bit run    = 0;

  logic [BW-1:0] q [COL][$];
  logic [DW-1:0] m_out;
  bit            m_ovf;
  bit            m_unf;

  task automatic chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] row(int r, int base);
    logic [DW-1:0] v;
    for (int c = 0; c < COL; c++) v[c*BW +: BW] = BW'(base + r * 16 + c);
    return v;
  endfunction

  function automatic int min_sz();
    int m;
    m = DEPTH;
    for (int c = 0; c < COL; c++) if (q[c].size() < m) m = q[c].size();
    return m;
  endfunction

  function automatic int max_sz();
    int m;
    m = 0;
    for (int c = 0; c < COL; c++) if (q[c].size() > m) m = q[c].size();
    return m;
  endfunction

  // behavioural model: queues per column, evaluated once per edge
  task automatic model_step();
    bit v, pop, on, un;
    if (reset) begin
      for (int c = 0; c < COL; c++) q[c].delete();
      m_out = '0;
      m_ovf = 0;
      m_unf = 0;
    end else if (bus.flush) begin
      for (int c = 0; c < COL; c++) q[c].delete();
    end else begin
      v  = (min_sz() > 0);
      pop = bus.rd && v;
      un = bus.rd && !v;
      on = 0;
      if (pop)
        for (int c = 0; c < COL; c++) m_out[c*BW +: BW] = q[c].pop_front();
      for (int c = 0; c < COL; c++)
        if (bus.wr[c]) begin
          if (q[c].size() < DEPTH) q[c].push_back(bus.in[c*BW +: BW]);
          else on = 1;
        end
      if (bus.clr_err) begin
        m_ovf = on;
        m_unf = un;
      end else begin
        m_ovf = m_ovf | on;
        m_unf = m_unf | un;
      end
    end
  endtask

  always @(negedge clk) begin
    if (run) begin
      chk("out",     bus.out,     m_out);
      chk("o_valid", bus.o_valid, min_sz() > 0);
      chk("o_ready", bus.o_ready, max_sz() < DEPTH);
      chk("o_full",  bus.o_full,  min_sz() == DEPTH);
      chk("o_afull", bus.o_afull, max_sz() >= TH);
      chk("o_rows",  bus.o_rows,  min_sz());
      chk("o_ovf",   bus.o_ovf,   m_ovf);
      chk("o_unf",   bus.o_unf,   m_unf);
    end
  end

  task automatic cyc(logic [COL-1:0] w, logic r, logic f = 0,
                     logic ce = 0, logic [DW-1:0] d = '0);
    bus.wr      = w;
    bus.rd      = r;
    bus.flush   = f;
    bus.clr_err = ce;
    bus.in      = d;
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    int wcnt [COL];
    int guard;
    int wmin;
    logic [COL-1:0] w;
    logic r;

    reset = 1'b1;
    bus.wr = '0; bus.rd = 0; bus.flush = 0;
    bus.clr_err = 0; bus.in = '0;
    cyc('0, 0);
    run = 1;
    cyc('0, 0);
    reset = 1'b0;

    // reset / idle
    cyc('0, 0);
    chk("rst_valid", bus.o_valid, 0);
    chk("rst_ready", bus.o_ready, 1);
    chk("rst_rows",  bus.o_rows, 0);
    chk("rst_out",   bus.out, 0);
    cyc('0, 1);
    chk("unf_set",   bus.o_unf, 1);
    chk("unf_out",   bus.out, 0);
    cyc('0, 0, 0, 1);
    chk("unf_clr",   bus.o_unf, 0);

    // fill 3 rows, pop them in order
    for (int k = 0; k < 3; k++) cyc('1, 0, 0, 0, row(k, 'h100));
    chk("fill_rows", bus.o_rows, 3);
    for (int k = 0; k < 3; k++) begin
      cyc('0, 1);
      chk("fill_pop", bus.out, row(k, 'h100));
    end
    chk("fill_empty", bus.o_valid, 0);

    // skew: col0 gets 5, others 2
    cyc('1, 0, 0, 0, row(0, 'h200));
    cyc('1, 0, 0, 0, row(1, 'h200));
    for (int k = 0; k < 3; k++) cyc(8'h01, 0, 0, 0, row(2 + k, 'h200));
    chk("skew_rows",  bus.o_rows, 2);
    chk("skew_valid", bus.o_valid, 1);
    cyc('0, 1);
    cyc('0, 1);
    chk("skew_out",   bus.out, row(1, 'h200));
    chk("skew_empty", bus.o_valid, 0);
    chk("skew_col0",  q[0].size(), 3);
    cyc('0, 0, 1);
    chk("skew_flush", bus.o_rows, 0);

    // fill to full, check almost-full threshold on the way
    for (int k = 0; k < DEPTH; k++) begin
      cyc('1, 0, 0, 0, row(k, 'h1000));
      if (k == TH - 2) chk("afull_below", bus.o_afull, 0);
      if (k == TH - 1) chk("afull_at",    bus.o_afull, 1);
    end
    chk("full_full",  bus.o_full, 1);
    chk("full_ready", bus.o_ready, 0);
    chk("full_afull", bus.o_afull, 1);
    cyc('1, 0, 0, 0, row(0, 'h5000));
    chk("full_ovf",   bus.o_ovf, 1);
    chk("full_keep",  bus.o_rows, DEPTH);
    cyc('0, 0, 0, 1);
    chk("ovf_clr",    bus.o_ovf, 0);
    cyc('1, 1, 0, 0, row(0, 'h6000));
    chk("fullrw_out", bus.out, row(0, 'h1000));
    chk("fullrw_cnt", bus.o_rows, DEPTH);
    chk("fullrw_ovf", bus.o_ovf, 0);
    cyc('0, 1);
    chk("fullrw_next", bus.out, row(1, 'h1000));
    cyc('0, 0, 1);

    // wrap: interleaved random writes/pops, no errors allowed
    for (int c = 0; c < COL; c++) wcnt[c] = 0;
    guard = 0;
    wmin  = 0;
    while (wmin < 3 * DEPTH + 5 && guard < 20000) begin
      w = '0;
      for (int c = 0; c < COL; c++)
        if (q[c].size() < DEPTH && $urandom_range(0, 3) != 0) w[c] = 1;
      r = (min_sz() > 0) && ($urandom_range(0, 1) == 1);
      cyc(w, r, 0, 0, {$urandom, $urandom, $urandom, $urandom});
      wmin = 1 << 30;
      for (int c = 0; c < COL; c++) begin
        wcnt[c] += int'(w[c]);
        if (wcnt[c] < wmin) wmin = wcnt[c];
      end
      guard++;
    end
    while (min_sz() > 0 && guard < 20000) begin
      cyc('0, 1);
      guard++;
    end
    if (guard >= 20000) chk("wrap_timeout", 1, 0);
    chk("wrap_ovf", bus.o_ovf, 0);
    chk("wrap_unf", bus.o_unf, 0);
    cyc('0, 0, 1);

    // flush mid-stream
    for (int k = 0; k < 10; k++) cyc('1, 0, 0, 0, row(k, 'h300));
    chk("fl_rows10", bus.o_rows, 10);
    cyc('0, 1);
    chk("fl_pop", bus.out, row(0, 'h300));
    cyc('0, 0, 1);
    chk("fl_rows0", bus.o_rows, 0);
    chk("fl_out",   bus.out, row(0, 'h300));

    // overflow and clear in the same cycle
    for (int k = 0; k < DEPTH; k++) cyc(8'h01, 0, 0, 0, row(k, 'h400));
    cyc(8'h01, 0, 0, 1, row(0, 'h700));
    chk("ovf_win", bus.o_ovf, 1);
    cyc('0, 0, 0, 1);
    cyc('0, 0, 1);

    // random traffic
    for (int k = 0; k < 3000; k++) begin
      reset = ($urandom_range(0, 199) == 0);
      cyc(($urandom_range(0, 3) == 0) ? COL'($urandom) : '1,
          $urandom_range(0, 2) == 0,
          $urandom_range(0, 59) == 0,
          $urandom_range(0, 19) == 0,
          {$urandom, $urandom, $urandom, $urandom});
    end
    reset = 1'b0;
    cyc('0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
